// File: rtl/reg_dump_tx.sv
// reg_dump_tx: streams a 20-word debug frame holding the header, a PC
// snapshot, R0..R15, the condition flags and an XOR checksum. The processor
// is held frozen while the frame is in flight so that the register file
// stays coherent.
module reg_dump_tx #(
    parameter logic [15:0] HEADER = 16'hD0C5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [15:0] PC,
    input  logic        N_ff,
    input  logic        Z_ff,
    input  logic        V_ff,
    output logic [3:0]  rf_addr,
    input  logic [15:0] rf_data,
    output logic        freeze,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PCW,
        S_REGS,
        S_FLG,
        S_CSUM
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;
    logic [15:0] r_acc;
    logic [15:0] w_acc_nxt;
    logic [15:0] r_pc;
    logic [2:0]  r_flags;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_snap;
    logic        w_xfer;

    // State, register index, running checksum and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_acc   <= 16'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Capture PC and flags on the trigger edge so that later changes cannot leak into the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= 16'd0;
            r_flags <= 3'd0;
        end else if (w_snap) begin
            r_pc    <= PC;
            r_flags <= {N_ff, Z_ff, V_ff};
        end
    end

    // Output word selection, handshake and next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_done_nxt  = 1'b0;
        w_snap      = 1'b0;
        dout        = 16'd0;
        dout_valid  = 1'b0;
        dout_last   = 1'b0;
        rf_addr     = 4'd0;
        freeze      = 1'b0;

        // The presented word depends only on registered state (plus rf_data,
        // which the frozen processor holds still), so it stays stable while
        // the sink stalls.
        case (r_state)
            S_HDR: begin
                dout       = HEADER;
                dout_valid = 1'b1;
            end
            S_PCW: begin
                dout       = r_pc;
                dout_valid = 1'b1;
            end
            S_REGS: begin
                rf_addr    = r_idx;
                dout       = rf_data;
                dout_valid = 1'b1;
            end
            S_FLG: begin
                dout       = {13'd0, r_flags};
                dout_valid = 1'b1;
            end
            S_CSUM: begin
                dout       = r_acc;
                dout_valid = 1'b1;
                dout_last  = 1'b1;
            end
            default: begin
                dout_valid = 1'b0;
            end
        endcase

        freeze = (r_state != S_IDLE);
        w_xfer = dout_valid && dout_ready;

        // Fold each accepted word into the checksum; the checksum word itself
        // is not folded.
        if (w_xfer && r_state != S_CSUM) begin
            w_acc_nxt = r_acc ^ dout;
        end

        case (r_state)
            S_IDLE: begin
                if (trigger) begin
                    w_state_nxt = S_HDR;
                    w_snap      = 1'b1;
                    w_acc_nxt   = 16'd0;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_HDR: begin
                if (w_xfer) w_state_nxt = S_PCW;
            end
            S_PCW: begin
                if (w_xfer) begin
                    w_state_nxt = S_REGS;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_REGS: begin
                if (w_xfer) begin
                    if (r_idx == 4'd15) begin
                        w_state_nxt = S_FLG;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            S_FLG: begin
                if (w_xfer) w_state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (w_xfer) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign done = r_done;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Scoreboard bench for reg_dump_tx: stimulus pushes expected words, and a
// negedge monitor pops and compares them on every transfer.
module tb_reg_dump_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] PC = 16'h0040;
    logic        N_ff = 1'b0;
    logic        Z_ff = 1'b1;
    logic        V_ff = 1'b0;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;
    logic        freeze;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        dout_last;
    logic        done;

    logic [15:0] rf [16];
    logic [15:0] exp_frame [20];

    typedef struct packed {
        logic [15:0] w;
        logic        last;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    reg_dump_tx dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .PC        (PC),
        .N_ff      (N_ff),
        .Z_ff      (Z_ff),
        .V_ff      (V_ff),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .freeze    (freeze),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .done      (done)
    );

    assign rf_data = rf[rf_addr];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < 20; i++) sb.push_back(exp_t'{w: exp_frame[i], last: (i == 19)});
    endtask

    // Monitor: checks stall stability and pops the scoreboard on each transfer.
    logic        p_stall = 1'b0;
    logic [15:0] p_dout;
    logic        p_last;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("stall_valid", dout_valid, 1);
                chk("stall_dout", dout, p_dout);
                chk("stall_last", dout_last, p_last);
            end
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected no transfer", dout);
                end else begin
                    e = sb.pop_front();
                    chk("word", dout, e.w);
                    chk("last", dout_last, e.last);
                end
            end
            p_stall = dout_valid && !dout_ready;
            p_dout  = dout;
            p_last  = dout_last;
        end
    end

    // One frame from a single trigger pulse; optional ready toggling,
    // input changes after the trigger, and re-triggering during the frame.
    task automatic run_frame(input bit tog, input bit chg, input bit retrig, input int exp_cyc);
        int c = 0;
        int frz_lo = 0;
        bit seen = 0;
        push_frame();
        @(posedge clk); #1;
        trigger = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        if (chg) begin
            PC = 16'h1234;
            N_ff = 1'b1;
        end
        if (tog) dout_ready = 1'b0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (c == 1) chk("hdr_rf_addr", rf_addr, 0);
            if (done) begin
                seen = 1;
                break;
            end
            if (!freeze) frz_lo++;
            @(posedge clk); #1;
            if (tog) dout_ready = ~dout_ready;
            if (retrig) trigger = (c < 16) ? ~trigger : 1'b0;
        end
        chk("done_seen", seen, 1);
        chk("done_cycle", c, exp_cyc);
        chk("freeze_gaps", frz_lo, 0);
        chk("done_idle_valid", dout_valid, 0);
        chk("done_idle_freeze", freeze, 0);
        chk("sb_empty", sb.size(), 0);
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        PC = 16'h0040;
        N_ff = 1'b0;
        trigger = 1'b0;
        dout_ready = 1'b1;
    endtask

    initial begin
        int c;
        int nd;
        int idle;
        int dn[3];
        bit found;

        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        rf[1]  = 16'h0022;
        rf[2]  = 16'h0011;
        rf[3]  = 16'h5555;
        rf[11] = 16'hAAAA;
        rf[15] = 16'hFFFF;
        exp_frame = '{16'hD0C5, 16'h0040, 16'h0000, 16'h0022, 16'h0011, 16'h5555,
                      16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                      16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 16'hD0B4};

        // Reset state before any clock edge.
        #2;
        chk("rst_valid", dout_valid, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_done", done, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_dout", dout, 0);
        chk("rst_rf_addr", rf_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_valid", dout_valid, 0);

        run_frame(0, 0, 0, 21);   // basic frame, ready always high
        run_frame(1, 0, 0, 41);   // ready toggling: checksum transfers in cycle 40
        run_frame(0, 1, 0, 21);   // PC/flags change after trigger edge
        run_frame(0, 0, 1, 21);   // repeated triggers during the frame

        // Asynchronous reset while presenting R7.
        push_frame();
        @(posedge clk); #1;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dout_valid && rf_addr == 4'd7) begin
                found = 1;
                break;
            end
        end
        chk("reach_r7", found, 1);
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", dout_valid, 0);
        chk("arst_freeze", freeze, 0);
        chk("arst_rf_addr", rf_addr, 0);
        chk("arst_dout", dout, 0);
        chk("arst_last", dout_last, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", dout_valid, 0);
            chk("post_rst_freeze", freeze, 0);
        end
        run_frame(0, 0, 0, 21);

        // Trigger held high for 50 edges: frames start at edges 0, 21 and 42.
        for (int i = 0; i < 3; i++) push_frame();
        @(posedge clk); #1;
        trigger = 1'b1;
        @(posedge clk);
        c = 0;
        nd = 0;
        idle = 0;
        while (c < 150) begin
            @(negedge clk);
            c++;
            if (done && nd < 3) begin
                dn[nd] = c;
                nd++;
            end
            if (!dout_valid && c <= 62) idle++;
            if (nd == 3) break;
            @(posedge clk); #1;
            if (c == 49) trigger = 1'b0;
        end
        chk("hold_frames", nd, 3);
        chk("hold_done0", dn[0], 21);
        chk("hold_done1", dn[1], 42);
        chk("hold_done2", dn[2], 63);
        chk("hold_idle_cycles", idle, 2);
        chk("hold_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
